// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-to-WB pipeline stage.
// Aligns and extends load data from the data cache, then buffers results in
// a small in-order FIFO with valid/ready handshakes on both sides.
// Optional feature: define MEMWB_EXCEPT_SQUASH_EN to clear the stored register
// write enable of any instruction that arrives with its exception flag set.
module mem_wb_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    output logic        MEM_Ready,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_DMOut,
    input  logic        MEM_ReadMem,
    input  logic [1:0]  MEM_LoadSize,
    input  logic        MEM_LoadUnsigned,
    input  logic        MEM_RegWr,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_ExceptFlag,
    input  logic        Flush,
    output logic        WB_Valid,
    input  logic        WB_Ready,
    output logic [31:0] WB_PC,
    output logic [31:0] WB_Data,
    output logic [4:0]  WB_Dst,
    output logic        WB_RegWr,
    output logic        WB_ExceptFlag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SIZE_WORD  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_BYTE  = 2'b10,
        SIZE_WORD2 = 2'b11
    } load_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        reg_wr;
        logic        except_flag;
    } entry_t;

    entry_t           buf_mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             enq;
    logic             deq;
    logic [15:0]      lane_half;
    logic [7:0]       lane_byte;
    logic [31:0]      aligned_data;

    // Ready depends only on the registered occupancy, never on WB_Ready.
    assign MEM_Ready = (count != CNT_W'(DEPTH));
    assign WB_Valid  = (count != '0);
    assign enq       = MEM_Valid && MEM_Ready && !Flush;
    assign deq       = WB_Valid && WB_Ready && !Flush;
    assign head      = buf_mem[rd_ptr];

    // Lane selection and sign/zero extension of the raw cache word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        lane_half    = MEM_ALUOut[1] ? MEM_DMOut[31:16] : MEM_DMOut[15:0];
        lane_byte    = MEM_DMOut[7:0];
        aligned_data = MEM_ALUOut;
        case (MEM_ALUOut[1:0])
            2'd0:    lane_byte = MEM_DMOut[7:0];
            2'd1:    lane_byte = MEM_DMOut[15:8];
            2'd2:    lane_byte = MEM_DMOut[23:16];
            default: lane_byte = MEM_DMOut[31:24];
        endcase
        if (MEM_ReadMem) begin
            case (load_size_e'(MEM_LoadSize))
                SIZE_HALF: aligned_data = {{16{lane_half[15] & ~MEM_LoadUnsigned}}, lane_half};
                SIZE_BYTE: aligned_data = {{24{lane_byte[7] & ~MEM_LoadUnsigned}}, lane_byte};
                default:   aligned_data = MEM_DMOut;
            endcase
        end
    end

    // Assemble the entry to store; the optional squash clears its write enable.
    always_comb begin
        new_entry.pc          = MEM_PC;
        new_entry.data        = aligned_data;
        new_entry.dst         = MEM_Dst;
        new_entry.except_flag = MEM_ExceptFlag;
`ifdef MEMWB_EXCEPT_SQUASH_EN
        new_entry.reg_wr      = MEM_RegWr & ~MEM_ExceptFlag;
`else
        new_entry.reg_wr      = MEM_RegWr;
`endif
    end

    // Entry storage: written on enqueue only.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; validity comes solely from count, so stale contents are never observed.
        if (enq) begin
            buf_mem[wr_ptr] <= new_entry;
        end
    end

    // Occupancy and pointer bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (Flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // WB outputs come straight from the head entry, reset values when empty.
    always_comb begin
        WB_PC         = RESET_PC;
        WB_Data       = '0;
        WB_Dst        = '0;
        WB_RegWr      = 1'b0;
        WB_ExceptFlag = 1'b0;
        if (WB_Valid) begin
            WB_PC         = head.pc;
            WB_Data       = head.data;
            WB_Dst        = head.dst;
            WB_RegWr      = head.reg_wr;
            WB_ExceptFlag = head.except_flag;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM-to-WB pipeline stage downstream of the data cache.
- Consumes the cache's raw read word (MEM_DMOut), the effective address and load type, and performs byte/halfword lane selection with sign/zero extension.
- Buffers results in a small in-order FIFO (skid buffer) with valid/ready handshakes on both sides, so a WB-side stall does not drop in-flight MEM results.
- Squashes register writeback for excepting instructions and supports a pipeline flush.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, >=2.
- RESET_PC, 32'hBFC00000, value driven on WB_PC while empty and after reset.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- MEM_Valid  in  1  MEM stage presents an instruction
- MEM_Ready  out  1  stage can accept (buffer not full)
- MEM_PC  in  32  instruction PC
- MEM_ALUOut  in  32  ALU result / effective address
- MEM_DMOut  in  32  raw word read from data cache
- MEM_ReadMem  in  1  instruction is a load
- MEM_LoadSize  in  2  00 word, 01 half, 10 byte, 11 treated as word
- MEM_LoadUnsigned  in  1  1 = zero-extend (LBU/LHU)
- MEM_RegWr  in  1  instruction writes GPR
- MEM_Dst  in  5  destination register
- MEM_ExceptFlag  in  1  any exception bit set in the MEM exception vector
- Flush  in  1  synchronous flush of all buffered entries
- WB_Valid  out  1  head entry valid
- WB_Ready  in  1  WB accepts head entry
- WB_PC  out  32  head PC
- WB_Data  out  32  head writeback data
- WB_Dst  out  5  head destination
- WB_RegWr  out  1  head write enable, gated by WB_Valid
- WB_ExceptFlag  out  1  head exception flag

Behaviour:
- Reset (async, rst=1): count=0, read/write pointers=0, WB_Valid=0, WB_RegWr=0, WB_ExceptFlag=0, WB_Data=0, WB_Dst=0, WB_PC=RESET_PC, MEM_Ready=1. Reset asserted mid-transfer discards all entries.
- Enqueue: when MEM_Valid && MEM_Ready && !Flush. Data is aligned at enqueue and the computed value is stored.
- Dequeue: when WB_Valid && WB_Ready && !Flush.
- Latency: an entry enqueued at edge N appears on WB_* after edge N (one cycle).
- WB outputs come directly from the head entry. When empty, they show reset values; WB_RegWr=0.
- MEM_Ready = (count != DEPTH). Derived only from registered count, with no combinational path from WB_Ready.
- Simultaneous enqueue and dequeue: count unchanged, order preserved.
- When full, no enqueue occurs even if a dequeue happens in the same cycle (no bypass).
- Flush=1: count and pointers cleared at the next edge. MEM_Valid and WB_Ready are ignored that cycle, and no handshake completes.
- Data selection, non-load (MEM_ReadMem=0): WB_Data = MEM_ALUOut.
- Data selection, word: WB_Data = MEM_DMOut.
- Data selection, half: lane = MEM_ALUOut[1] ? DMOut[31:16] : DMOut[15:0].
- Data selection, byte: lane = DMOut[8*a+7:8*a], where a = MEM_ALUOut[1:0].
- Extension: sign-extend the lane's top bit unless MEM_LoadUnsigned, then zero-extend.
- Misaligned addresses are not checked here; the exception arrives via MEM_ExceptFlag.
- MEM_ExceptFlag is stored per entry and presented on WB_ExceptFlag.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro MEMWB_EXCEPT_SQUASH_EN.
- Defined: an entry enqueued with MEM_ExceptFlag=1 is stored with RegWr=0, so no GPR write ever occurs for an excepting instruction.
- Undefined: RegWr is stored unchanged, and WB must gate on WB_ExceptFlag.
- All other behaviour is identical in both cases.

Test Plan:
- Reset then idle: WB_Valid=0, WB_PC=32'hBFC00000, MEM_Ready=1. Assert rst mid-stream with 2 entries held: outputs return to reset values immediately, without waiting for a clock edge.
- LB: addr 0x1003, DMOut 0x80FF7F01, unsigned=0 -> WB_Data=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x1002 -> 0xFFFF80FF. LHU addr 0x1000 -> 0x00007F01.
- Non-load: ALUOut=0x12345678, RegWr=1, Dst=5 -> one cycle later WB_Data=0x12345678, WB_Dst=5, WB_RegWr=1.
- Backpressure: WB_Ready=0, enqueue PCs 0x100, 0x104 -> MEM_Ready=0 after the 2nd. Third MEM_Valid is held until WB_Ready=1. Drain order is 0x100, 0x104, 0x108.
- Flush with 2 entries and MEM_Valid=1 the same cycle -> next cycle WB_Valid=0, count=0, incoming instruction not captured.
- MEM_ExceptFlag=1, RegWr=1 -> WB_ExceptFlag=1. WB_RegWr=0 with MEMWB_EXCEPT_SQUASH_EN defined, 1 without.
